fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 10'h000: first program address fetched after reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000: instruction word driven to the decoder when no valid instruction is present.
REQ-003 Parameter HALT_INSTR, default 16'hFFFF: full 16-bit word that halts fetch when valid in the instruction register (IR).
REQ-004 Clock  in  1  single clock; all state updates on the rising edge.
REQ-005 Reset  in  1  synchronous, active-high.
REQ-006 iStall  in  1  freeze request from the datapath or data memory.
REQ-007 iBranch_taken  in  1  decoder conditional-branch-taken indication.
REQ-008 iJumpTaken  in  1  decoder unconditional-jump indication.
REQ-009 iBranch_dir  in  10  decoder absolute target address.
REQ-010 iRomData  in  16  synchronous instruction ROM read data; valid one cycle after an enabled address.
REQ-011 oRomAddr  out  10  ROM address, equal to the registered fetch PC.
REQ-012 oRomEn  out  1  ROM read enable; the ROM holds its data output while low.
REQ-013 oInstruction  out  16  IR contents, feeding the decoder wInstruction.
REQ-014 oInstrValid  out  1  IR holds a real instruction.
REQ-015 oPC  out  10  address from which oInstruction was fetched.
REQ-016 oHalted  out  1  sequencer is in HALT.

Function
REQ-017 The FSM SHALL have the states BOOT, RUN, FLUSH and HALT.
REQ-018 In BOOT and FLUSH, iRomData is invalid and SHALL NOT be loaded into the IR.
REQ-019 In RUN, iRomData is valid for the previous oRomAddr.
REQ-020 Redirect SHALL be defined as (iBranch_taken | iJumpTaken) & oInstrValid & ~iStall.
- Redirect SHALL be ignored while oInstrValid=0.
REQ-021 Each non-stalled, non-HALT cycle SHALL set oRomEn=1, and on the edge:
- fetch PC <= redirect ? iBranch_dir : fetch PC+1, with 10-bit wrap (10'h3FF+1 = 10'h000).
- Data-address tag <= oRomAddr.
REQ-022 On a BOOT edge without stall: state <= RUN; IR unchanged (NOP_INSTR, invalid).
REQ-023 On a RUN edge without stall and without redirect: IR <= iRomData, oInstrValid <= 1, oPC <= tag.
REQ-024 On a RUN edge with redirect: IR <= NOP_INSTR, oInstrValid <= 0, state <= FLUSH; the in-flight ROM word is discarded.
REQ-025 On a FLUSH edge without stall: state <= RUN; IR stays NOP/invalid.
- Consequence: exactly two invalid decode cycles follow every redirect.
REQ-026 While iStall=1 in BOOT, RUN or FLUSH, the sequencer SHALL hold state.
- oRomEn=0.
- fetch PC, tag, IR, oInstrValid and oPC unchanged.
- A branch or jump present in the IR is taken on the first cycle with iStall=0.
REQ-027 When IR==HALT_INSTR, oInstrValid=1 and iStall=0, the next edge SHALL:
- set state <= HALT.
- set IR <= NOP_INSTR and oInstrValid <= 0.
REQ-028 In HALT the sequencer SHALL drive oRomEn=0 and oHalted=1, ignore all inputs except Reset, and remain in HALT until Reset.
REQ-029 Simultaneous branch and jump SHALL be treated as one redirect to iBranch_dir.
REQ-030 The first valid instruction SHALL reach the decoder 2 edges after Reset deasserts, with oPC=RESET_VECTOR.
REQ-031 Sustained throughput without stalls or redirects SHALL be one instruction per cycle.

Reset
REQ-032 Reset=1 at any edge, including mid-stall, mid-FLUSH or in HALT, SHALL:
- set state <= BOOT and fetch PC <= RESET_VECTOR.
- set tag and oPC <= RESET_VECTOR.
- set IR <= NOP_INSTR, oInstrValid <= 0 and oHalted <= 0.
REQ-033 Reset SHALL take priority over stall, redirect and halt.
REQ-034 While Reset=1, oRomEn SHALL be 0.

Verification
REQ-035 Boot: ROM[n]=16'h1000+n, deassert Reset -> oRomAddr 0,1,2,…; oInstrValid rises on the 2nd edge; oInstruction 16'h1000,16'h1001,… with oPC 0,1,….
REQ-036 Jump: IR holds a jump at oPC=5, iJumpTaken=1, iBranch_dir=10'h120 -> oRomAddr=10'h120 the next cycle; two invalid cycles; then oInstruction=ROM[10'h120] with oPC=10'h120.
REQ-037 Stall over branch: branch in IR with iBranch_taken=1 and iStall=1 for 3 cycles -> oRomEn=0 and all outputs frozen for 3 cycles; redirect occurs on the first unstalled edge.
REQ-038 Wrap: RESET_VECTOR=10'h3FE -> oPC sequence 3FE, 3FF, 000, 001.
REQ-039 Halt: ROM[3]=16'hFFFF -> after oPC=3 is valid, oHalted=1 and oRomEn=0 on every later cycle; assert Reset -> boot sequence restarts from RESET_VECTOR.
REQ-040 Invalid-slot guard: iBranch_taken forced to 1 during the FLUSH cycles -> no additional redirect and no change to the fetch sequence.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives a synchronous ROM and loads the decoder IR, first instruction 2 edges after reset.
// iStall freezes all state and gates oRomEn; each redirect costs exactly two invalid decode slots.
module fetch_sequencer #(
    parameter logic [9:0]  RESET_VECTOR = 10'h000,
    parameter logic [15:0] NOP_INSTR    = 16'h0000,
    parameter logic [15:0] HALT_INSTR   = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iStall,
    input  logic        iBranch_taken,
    input  logic        iJumpTaken,
    input  logic [9:0]  iBranch_dir,
    input  logic [15:0] iRomData,
    output logic [9:0]  oRomAddr,
    output logic        oRomEn,
    output logic [15:0] oInstruction,
    output logic        oInstrValid,
    output logic [9:0]  oPC,
    output logic        oHalted
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

    state_t     state;
    logic [9:0] fetchPc;
    logic [9:0] tagPc;
    logic       advance;
    logic       redirect;
    logic       haltHit;

    assign advance  = (state != HALT) && !iStall;
    assign redirect = (iBranch_taken || iJumpTaken) && oInstrValid && !iStall;
    assign haltHit  = (oInstruction == HALT_INSTR) && oInstrValid && !iStall;
    assign oRomEn   = advance && !Reset;
    assign oRomAddr = fetchPc;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= BOOT;
            fetchPc      <= RESET_VECTOR;
            tagPc        <= RESET_VECTOR;
            oPC          <= RESET_VECTOR;
            oInstruction <= NOP_INSTR;
            oInstrValid  <= 1'b0;
            oHalted      <= 1'b0;
        end else if (advance) begin
            fetchPc <= redirect ? iBranch_dir : fetchPc + 10'd1;
            tagPc   <= fetchPc;
            case (state)
                BOOT, FLUSH: state <= RUN;
                RUN: begin
                    // A halt word wins over any branch decoded alongside it.
                    if (haltHit) begin
                        state        <= HALT;
                        oHalted      <= 1'b1;
                        oInstruction <= NOP_INSTR;
                        oInstrValid  <= 1'b0;
                    end else if (redirect) begin
                        state        <= FLUSH;
                        oInstruction <= NOP_INSTR;
                        oInstrValid  <= 1'b0;
                    end else begin
                        oInstruction <= iRomData;
                        oInstrValid  <= 1'b1;
                        oPC          <= tagPc;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a fetch-stream model checked every cycle plus hand-computed expectations.
module tb_fetch_sequencer;

    localparam logic [15:0] NOP_W  = 16'h0000;
    localparam logic [15:0] HALT_W = 16'hFFFF;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStall;
    logic        iBranch_taken;
    logic        iJumpTaken;
    logic [9:0]  iBranch_dir;

    logic [15:0] rom [0:1023];
    logic [15:0] romQA = 16'h0;
    logic [15:0] romQB = 16'h0;

    logic [9:0]  romAddr, bRomAddr;
    logic        romEn, bRomEn;
    logic [15:0] instr, bInstr;
    logic        instrValid, bInstrValid;
    logic [9:0]  pc, bPc;
    logic        halted, bHalted;

    int nTests = 0;
    int nFail  = 0;

    always #5 Clock = ~Clock;

    fetch_sequencer #(.RESET_VECTOR(10'h000), .NOP_INSTR(NOP_W), .HALT_INSTR(HALT_W)) dutA (
        .Clock(Clock), .Reset(Reset), .iStall(iStall), .iBranch_taken(iBranch_taken),
        .iJumpTaken(iJumpTaken), .iBranch_dir(iBranch_dir), .iRomData(romQA),
        .oRomAddr(romAddr), .oRomEn(romEn), .oInstruction(instr), .oInstrValid(instrValid),
        .oPC(pc), .oHalted(halted)
    );

    fetch_sequencer #(.RESET_VECTOR(10'h3FE), .NOP_INSTR(NOP_W), .HALT_INSTR(HALT_W)) dutB (
        .Clock(Clock), .Reset(Reset), .iStall(iStall), .iBranch_taken(iBranch_taken),
        .iJumpTaken(iJumpTaken), .iBranch_dir(iBranch_dir), .iRomData(romQB),
        .oRomAddr(bRomAddr), .oRomEn(bRomEn), .oInstruction(bInstr), .oInstrValid(bInstrValid),
        .oPC(bPc), .oHalted(bHalted)
    );

    // Synchronous ROMs that hold their output while the enable is low.
    always @(posedge Clock) if (romEn)  romQA <= rom[romAddr];
    always @(posedge Clock) if (bRomEn) romQB <= rom[bRomAddr];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a stream of fetched addresses; a ROM word becomes decodable one edge after
    // its address was fetched, unless a reset or redirect squashed it.
    logic        mReady = 1'b0;
    logic [9:0]  mFetch, mInflight, mPc;
    logic        mUsable, mValid, mHalted;
    logic [15:0] mIr;

    always @(posedge Clock) begin
        if (Reset) begin
            mReady  <= 1'b1;
            mFetch  <= 10'h000;
            mUsable <= 1'b0;
            mIr     <= NOP_W;
            mValid  <= 1'b0;
            mPc     <= 10'h000;
            mHalted <= 1'b0;
        end else if (mReady && !mHalted && !iStall) begin
            if (mValid && mIr == HALT_W) begin
                mHalted <= 1'b1;
                mIr     <= NOP_W;
                mValid  <= 1'b0;
            end else if ((iBranch_taken || iJumpTaken) && mValid) begin
                mIr     <= NOP_W;
                mValid  <= 1'b0;
                mUsable <= 1'b0;
                mFetch  <= iBranch_dir;
            end else begin
                if (mUsable) begin
                    mIr    <= rom[mInflight];
                    mValid <= 1'b1;
                    mPc    <= mInflight;
                end
                mInflight <= mFetch;
                mUsable   <= 1'b1;
                mFetch    <= mFetch + 10'd1;
            end
        end
    end

    always @(negedge Clock) begin
        if (mReady) begin
            check("model romEn", 16'(romEn), 16'(!Reset && !iStall && !mHalted));
            if (!mHalted) check("model romAddr", 16'(romAddr), 16'(mFetch));
            check("model instr", instr, mIr);
            check("model valid", 16'(instrValid), 16'(mValid));
            check("model pc", 16'(pc), 16'(mPc));
            check("model halted", 16'(halted), 16'(mHalted));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 16'h1000 + 16'(i);
        Reset = 1'b1; iStall = 1'b0; iBranch_taken = 1'b0; iJumpTaken = 1'b0; iBranch_dir = 10'h000;
        tick(); tick();
        check("reset romEn", 16'(romEn), 16'h0);
        check("reset valid", 16'(instrValid), 16'h0);
        check("reset instr", instr, 16'h0000);
        check("reset pc", 16'(pc), 16'h000);
        check("reset halted", 16'(halted), 16'h0);
        check("reset romAddr", 16'(romAddr), 16'h000);
        check("reset pc B", 16'(bPc), 16'h3FE);

        // Boot and wrap-around from 3FE.
        Reset = 1'b0;
        tick();
        check("boot e1 valid", 16'(instrValid), 16'h0);
        check("boot e1 romAddr", 16'(romAddr), 16'h001);
        tick();
        check("boot e2 valid", 16'(instrValid), 16'h1);
        check("boot e2 instr", instr, 16'h1000);
        check("boot e2 pc", 16'(pc), 16'h000);
        check("wrap pc0", 16'(bPc), 16'h3FE);
        check("wrap instr0", bInstr, 16'h13FE);
        tick();
        check("boot e3 instr", instr, 16'h1001);
        check("wrap pc1", 16'(bPc), 16'h3FF);
        tick();
        check("wrap pc2", 16'(bPc), 16'h000);
        tick();
        check("wrap pc3", 16'(bPc), 16'h001);
        tick(); tick();
        check("jump src pc", 16'(pc), 16'h005);

        // Jump at PC 5, with a spurious branch held through the two invalid slots.
        iJumpTaken = 1'b1; iBranch_dir = 10'h120;
        tick();
        check("jump romAddr", 16'(romAddr), 16'h120);
        check("jump slot1 valid", 16'(instrValid), 16'h0);
        iJumpTaken = 1'b0; iBranch_taken = 1'b1; iBranch_dir = 10'h055;
        tick();
        check("jump slot2 valid", 16'(instrValid), 16'h0);
        check("guard romAddr", 16'(romAddr), 16'h121);
        tick();
        iBranch_taken = 1'b0;
        check("jump target instr", instr, 16'h1120);
        check("jump target pc", 16'(pc), 16'h120);

        // Branch held under a 3-cycle stall.
        tick();
        iBranch_taken = 1'b1; iBranch_dir = 10'h200; iStall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall romEn", 16'(romEn), 16'h0);
            check("stall pc", 16'(pc), 16'h121);
            check("stall instr", instr, 16'h1121);
            check("stall romAddr", 16'(romAddr), 16'h123);
        end
        iStall = 1'b0;
        tick();
        iBranch_taken = 1'b0;
        check("stall branch romAddr", 16'(romAddr), 16'h200);
        tick(); tick();
        check("branch target instr", instr, 16'h1200);
        check("branch target pc", 16'(pc), 16'h200);

        // Plain stall: held ROM data must still be used.
        iStall = 1'b1;
        tick(); tick();
        iStall = 1'b0;
        tick(); tick();
        check("post-stall instr", instr, 16'h1202);
        check("post-stall pc", 16'(pc), 16'h202);

        // Simultaneous branch and jump to the top of memory, then wrap.
        iBranch_taken = 1'b1; iJumpTaken = 1'b1; iBranch_dir = 10'h3FF;
        tick();
        iBranch_taken = 1'b0; iJumpTaken = 1'b0;
        check("dual romAddr", 16'(romAddr), 16'h3FF);
        tick(); tick();
        check("dual target pc", 16'(pc), 16'h3FF);
        tick();
        check("dual wrap instr", instr, 16'h1000);

        // Reset during a stall.
        iStall = 1'b1; Reset = 1'b1;
        tick();
        check("stall reset valid", 16'(instrValid), 16'h0);
        check("stall reset pc", 16'(pc), 16'h000);
        check("stall reset romAddr", 16'(romAddr), 16'h000);
        iStall = 1'b0;
        rom[3] = HALT_W;
        tick();
        Reset = 1'b0;

        // Halt at PC 3; inputs toggled while halted must be ignored.
        repeat (5) tick();
        check("halt word pc", 16'(pc), 16'h003);
        check("halt word instr", instr, HALT_W);
        check("halt word halted", 16'(halted), 16'h0);
        tick();
        check("halted flag", 16'(halted), 16'h1);
        check("halted romEn", 16'(romEn), 16'h0);
        check("halted valid", 16'(instrValid), 16'h0);
        for (int k = 0; k < 4; k++) begin
            iJumpTaken = k[0]; iBranch_taken = k[1]; iStall = k[0]; iBranch_dir = 10'h0AA;
            tick();
            check("halt hold flag", 16'(halted), 16'h1);
            check("halt hold romEn", 16'(romEn), 16'h0);
        end
        iJumpTaken = 1'b0; iBranch_taken = 1'b0; iStall = 1'b0;
        Reset = 1'b1;
        tick();
        check("halt reset flag", 16'(halted), 16'h0);
        rom[3] = 16'h1003;
        Reset = 1'b0;
        tick(); tick();
        check("reboot pc", 16'(pc), 16'h000);
        check("reboot instr", instr, 16'h1000);
        check("reboot valid", 16'(instrValid), 16'h1);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
